// File: rtl/lock_ctrl_fsm.sv
// Keypad lock controller: sequences entry/store/compare phases, counts failures, times lockout.
// Latency: Moore outputs one cycle after the deciding input edge; CHECK adds one cycle before lockout.
// Backpressure: none; level buttons are held by the user, checker pulses are sampled only in RESULT.
module lock_ctrl_fsm #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int SLEEP_CYCLES   = 1000,
    parameter int UNLOCK_CYCLES  = 50,
    parameter int TIMEOUT_CYCLES = 500,
    parameter int AW             = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic          clk,
    input  logic          system_reset_n,
    input  logic          inputButton,
    input  logic          storeButton,
    input  logic          submitButton,
    input  logic          correct_password,
    input  logic          invalid_password,
    output logic          input_value,
    output logic          store_value,
    output logic          store_password,
    output logic          compare,
    output logic          unlock,
    output logic          locked_out,
    output logic [AW-1:0] attempts_left
);

    // The shared timer only ever needs to hold the largest reload value (limit - 1).
    localparam int TMAX_A = (SLEEP_CYCLES > UNLOCK_CYCLES) ? SLEEP_CYCLES : UNLOCK_CYCLES;
    localparam int TMAX   = (TMAX_A > TIMEOUT_CYCLES) ? TMAX_A : TIMEOUT_CYCLES;
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [AW-1:0] MAX_A    = AW'(MAX_ATTEMPTS);
    localparam logic [TW-1:0] T_TMO    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] T_SLEEP  = TW'(SLEEP_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_INPUT      = 4'd1,
        S_WAIT_INPUT = 4'd2,
        S_COMPARE    = 4'd3,
        S_RESULT     = 4'd4,
        S_UNLOCK     = 4'd5,
        S_CHECK      = 4'd6,
        S_SLEEP      = 4'd7,
        S_STORE      = 4'd8,
        S_WAIT_STORE = 4'd9,
        S_STORE_PW   = 4'd10
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [TW-1:0] timer_dec;
    logic [AW-1:0] fail_inc;
    logic          timer_zero;

    assign timer_dec  = timer_q - TW'(1);
    assign timer_zero = (timer_q == '0);
    // Failure count saturates so a stuck checker cannot wrap the counter.
    assign fail_inc   = (fail_q >= MAX_A) ? MAX_A : fail_q + AW'(1);

    // State, failure counter and shared timer registers.
    always_ff @(posedge clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q <= S_IDLE;
            fail_q  <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    // Next-state, counter and timer decisions.
    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (inputButton)      state_d = S_INPUT;
                else if (storeButton) state_d = S_STORE;
            end
            S_INPUT: begin
                if (!inputButton) begin
                    state_d = S_WAIT_INPUT;
                    timer_d = T_TMO;
                end
            end
            S_WAIT_INPUT: begin
                if (submitButton)     state_d = S_COMPARE;
                else if (inputButton) state_d = S_INPUT;
                else if (timer_zero)  state_d = S_IDLE;  // abandoned entry, not a failure
                else                  timer_d = timer_dec;
            end
            S_COMPARE: begin
                if (!submitButton) begin
                    state_d = S_RESULT;
                    timer_d = T_TMO;
                end
            end
            S_RESULT: begin
                // A mismatch beats a simultaneous match; a silent checker counts as a mismatch.
                if (invalid_password || (!correct_password && timer_zero)) begin
                    state_d = S_CHECK;
                    fail_d  = fail_inc;
                end else if (correct_password) begin
                    state_d = S_UNLOCK;
                    fail_d  = '0;
                    timer_d = T_UNLOCK;
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_UNLOCK: begin
                if (timer_zero) state_d = S_IDLE;
                else            timer_d = timer_dec;
            end
            S_CHECK: begin
                if (fail_q >= MAX_A) begin
                    state_d = S_SLEEP;
                    timer_d = T_SLEEP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SLEEP: begin
                if (timer_zero) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_STORE: begin
                if (!storeButton) begin
                    state_d = S_WAIT_STORE;
                    timer_d = T_TMO;
                end
            end
            S_WAIT_STORE: begin
                if (storeButton)       state_d = S_STORE;
                else if (submitButton) state_d = S_STORE_PW;
                else if (timer_zero)   state_d = S_IDLE;
                else                   timer_d = timer_dec;
            end
            S_STORE_PW: begin
                if (!submitButton) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        input_value    = 1'b0;
        store_value    = 1'b0;
        store_password = 1'b0;
        compare        = 1'b0;
        unlock         = 1'b0;
        locked_out     = 1'b0;
        case (state_q)
            S_INPUT:    input_value    = 1'b1;
            S_STORE:    store_value    = 1'b1;
            S_STORE_PW: store_password = 1'b1;
            S_COMPARE:  compare        = 1'b1;
            S_UNLOCK:   unlock         = 1'b1;
            S_SLEEP:    locked_out     = 1'b1;
            default: ;
        endcase
    end

    assign attempts_left = MAX_A - fail_q;

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// Bench for lock_ctrl_fsm: directed scenarios followed by phase-biased random traffic.
// Expected outputs come from a cycle-count reference model of the lock behaviour.
// Inputs are driven on the falling edge; outputs are compared just before each drive.
module tb_lock_ctrl_fsm;

    localparam int MAXA = 3;
    localparam int SLP  = 20;
    localparam int UNL  = 8;
    localparam int TMO  = 16;
    localparam int AW   = $clog2(MAXA + 1);

    logic          clk = 1'b0;
    logic          system_reset_n = 1'b0;
    logic          inputButton = 1'b0;
    logic          storeButton = 1'b0;
    logic          submitButton = 1'b0;
    logic          correct_password = 1'b0;
    logic          invalid_password = 1'b0;
    logic          input_value, store_value, store_password, compare, unlock, locked_out;
    logic [AW-1:0] attempts_left;

    lock_ctrl_fsm #(
        .MAX_ATTEMPTS  (MAXA),
        .SLEEP_CYCLES  (SLP),
        .UNLOCK_CYCLES (UNL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk             (clk),
        .system_reset_n  (system_reset_n),
        .inputButton     (inputButton),
        .storeButton     (storeButton),
        .submitButton    (submitButton),
        .correct_password(correct_password),
        .invalid_password(invalid_password),
        .input_value     (input_value),
        .store_value     (store_value),
        .store_password  (store_password),
        .compare         (compare),
        .unlock          (unlock),
        .locked_out      (locked_out),
        .attempts_left   (attempts_left)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the user-visible phase, cycles spent in it, and failures so far.
    typedef enum int {
        P_IDLE, P_ENTRY, P_ENTRY_PAUSE, P_SUBMIT, P_AWAIT, P_OPEN,
        P_VERDICT, P_LOCKED, P_NEWPW, P_NEWPW_PAUSE, P_COMMIT
    } phase_t;

    phase_t m_phase = P_IDLE;
    int     m_dwell = 0;
    int     m_fails = 0;

    int unlock_seen = 0;
    int lock_seen   = 0;

    function automatic logic [5:0] model_outs();
        case (m_phase)
            P_ENTRY:  return 6'b100000;
            P_NEWPW:  return 6'b010000;
            P_COMMIT: return 6'b001000;
            P_SUBMIT: return 6'b000100;
            P_OPEN:   return 6'b000010;
            P_LOCKED: return 6'b000001;
            default:  return 6'b000000;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_dwell = 0;
        m_fails = 0;
    endtask

    // Advance the model by one clock using the inputs that the DUT will sample.
    task automatic model_step();
        phase_t np;
        np = m_phase;
        case (m_phase)
            P_IDLE:        if (inputButton) np = P_ENTRY; else if (storeButton) np = P_NEWPW;
            P_ENTRY:       if (!inputButton) np = P_ENTRY_PAUSE;
            P_ENTRY_PAUSE: if (submitButton) np = P_SUBMIT;
                           else if (inputButton) np = P_ENTRY;
                           else if (m_dwell == TMO - 1) np = P_IDLE;
            P_SUBMIT:      if (!submitButton) np = P_AWAIT;
            P_AWAIT: begin
                if (invalid_password || (!correct_password && m_dwell == TMO - 1)) begin
                    np = P_VERDICT;
                    m_fails = (m_fails < MAXA) ? m_fails + 1 : MAXA;
                end else if (correct_password) begin
                    np = P_OPEN;
                    m_fails = 0;
                end
            end
            P_OPEN:        if (m_dwell == UNL - 1) np = P_IDLE;
            P_VERDICT:     np = (m_fails >= MAXA) ? P_LOCKED : P_IDLE;
            P_LOCKED: begin
                if (m_dwell == SLP - 1) begin
                    np = P_IDLE;
                    m_fails = 0;
                end
            end
            P_NEWPW:       if (!storeButton) np = P_NEWPW_PAUSE;
            P_NEWPW_PAUSE: if (storeButton) np = P_NEWPW;
                           else if (submitButton) np = P_COMMIT;
                           else if (m_dwell == TMO - 1) np = P_IDLE;
            P_COMMIT:      if (!submitButton) np = P_IDLE;
            default:       np = P_IDLE;
        endcase
        m_dwell = (np == m_phase) ? m_dwell + 1 : 0;
        m_phase = np;
    endtask

    // One clock: compare outputs, drive new inputs, advance the model.
    task automatic cyc(input logic i, input logic s, input logic b, input logic g, input logic x);
        @(negedge clk);
        chk("outs", int'({input_value, store_value, store_password, compare, unlock, locked_out}),
            int'(model_outs()));
        chk("attempts_left", int'(attempts_left), MAXA - m_fails);
        if (unlock)     unlock_seen++;
        if (locked_out) lock_seen++;
        inputButton      = i;
        storeButton      = s;
        submitButton     = b;
        correct_password = g;
        invalid_password = x;
        model_step();
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
    endtask

    // Enter a code, submit it, and have the checker reject it.
    task automatic fail_seq();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        logic ri, rs, rb, rg, rx;
        int   mode;
        int   r;
        mode = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_outs", int'({input_value, store_value, store_password, compare, unlock, locked_out}), 0);
        chk("rst_attempts", int'(attempts_left), MAXA);
        system_reset_n = 1'b1;
        model_reset();

        // Correct code: compare while submit held, unlock for exactly UNL cycles.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        quiet(2);
        unlock_seen = 0;
        cyc(0, 0, 0, 1, 0);
        quiet(UNL + 3);
        chk("unlock_width", unlock_seen, UNL);
        chk("attempts_after_unlock", int'(attempts_left), MAXA);

        // Three rejections lock the keypad for SLP cycles regardless of buttons.
        fail_seq();
        chk("attempts_1fail", int'(attempts_left), MAXA - 1);
        fail_seq();
        chk("attempts_2fail", int'(attempts_left), MAXA - 2);
        lock_seen = 0;
        fail_seq();
        for (int k = 0; k < SLP; k++)
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        quiet(4);
        chk("sleep_width", lock_seen, SLP);
        chk("attempts_after_sleep", int'(attempts_left), MAXA);

        // Simultaneous verdicts: mismatch wins, no unlock.
        unlock_seen = 0;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        quiet(4);
        chk("both_no_unlock", unlock_seen, 0);
        chk("both_attempts", int'(attempts_left), MAXA - 1);

        // Silent checker times out into a failure.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        quiet(TMO + 2);
        chk("result_timeout_attempts", int'(attempts_left), MAXA - 2);

        // Success clears the failures.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        quiet(UNL + 2);
        chk("success_clears", int'(attempts_left), MAXA);

        // Store path.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        quiet(2);

        // Asynchronous reset in the middle of a lockout.
        fail_seq();
        fail_seq();
        fail_seq();
        quiet(5);
        chk("pre_rst_locked", int'(locked_out), 1);
        #2 system_reset_n = 1'b0;
        #1;
        chk("arst_locked_out", int'(locked_out), 0);
        chk("arst_attempts", int'(attempts_left), MAXA);
        model_reset();
        @(negedge clk);
        chk("arst_outs", int'({input_value, store_value, store_password, compare, unlock, locked_out}), 0);
        system_reset_n = 1'b1;

        // Random traffic biased by the model phase so every path is reached.
        for (int n = 0; n < 6000; n++) begin
            ri = 0; rs = 0; rb = 0; rg = 0; rx = 0;
            r  = $urandom_range(0, 9);
            case (m_phase)
                P_IDLE: begin
                    mode = $urandom_range(0, 9);
                    ri = (r < 5) || (r == 9);
                    rs = (r >= 5 && r < 7) || (r == 9);
                end
                P_ENTRY:       ri = (r < 7);
                P_ENTRY_PAUSE: if (mode != 6) begin rb = (r < 4); ri = (r == 4); end
                P_SUBMIT:      rb = (r < 6);
                P_AWAIT: begin
                    rb = 1'($urandom);
                    if (mode < 7 && $urandom_range(0, 2) == 0) begin
                        r  = $urandom_range(0, 9);
                        rg = (r < 4) || (r == 9);
                        rx = (r >= 4);
                    end
                end
                P_OPEN, P_LOCKED, P_VERDICT: begin
                    ri = 1'($urandom); rs = 1'($urandom); rb = 1'($urandom);
                end
                P_NEWPW:       rs = (r < 7);
                P_NEWPW_PAUSE: if (mode != 6) begin rb = (r < 4); rs = (r == 4); end
                P_COMMIT:      rb = (r < 6);
                default: ;
            endcase
            if (m_phase != P_AWAIT && $urandom_range(0, 7) == 0) begin
                rg = 1'($urandom);
                rx = 1'($urandom);
            end
            cyc(ri, rs, rb, rg, rx);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lock_ctrl_fsm.md
Name: lock_ctrl_fsm

Overview:
Parametrised Moore controller for the keypad lock, the next generation of the single-attempt lock FSM. It sequences input, store and compare phases, counts failed attempts, and enforces a timed lockout with an internal timer that replaces the external end_sleep strobe. It also holds unlock for a fixed pulse width and times out stalled entry or checker handshakes. It sits between the debounced buttons and the code checker / password register.

Parameters:
MAX_ATTEMPTS, 3, consecutive failures that trigger lockout (>=1)
SLEEP_CYCLES, 1000, lockout duration in clk cycles (>=1)
UNLOCK_CYCLES, 50, unlock output width in clk cycles (>=1)
TIMEOUT_CYCLES, 500, idle limit in WAIT_INPUT/WAIT_STORE and checker-response limit in RESULT (>=1)
AW, $clog2(MAX_ATTEMPTS+1), attempt counter width (derived)

Ports:
clk  in  1  system clock, rising edge
system_reset_n  in  1  asynchronous active-low reset
inputButton  in  1  debounced, level; digit-entry button
storeButton  in  1  debounced, level; new-password button
submitButton  in  1  debounced, level
correct_password  in  1  checker pulse, match
invalid_password  in  1  checker pulse, mismatch
input_value  out  1  high in INPUT
store_value  out  1  high in STORE
store_password  out  1  high in STORE_PW (commit to password register)
compare  out  1  high in COMPARE
unlock  out  1  high in UNLOCK
locked_out  out  1  high in SLEEP
attempts_left  out  AW  MAX_ATTEMPTS - fail_cnt

Behaviour:
- One clock, clk; reset asynchronous active-low on system_reset_n. Reset: state=IDLE, fail_cnt=0, timer=0, all 1-bit outputs 0, attempts_left=MAX_ATTEMPTS.
- Outputs decode from the state register only. There is no input-to-output path, and every output has a defined value in every state, so no latches.
- One shared down-counter, timer. It is loaded on entry to each timed state and decrements once per cycle in that state.
- IDLE: inputButton -> INPUT; else storeButton -> STORE; else stay. inputButton wins if both are pressed.
- INPUT: stay while inputButton; on release -> WAIT_INPUT, timer=TIMEOUT_CYCLES-1.
- WAIT_INPUT: submitButton -> COMPARE; else inputButton -> INPUT; else timer==0 -> IDLE (abandoned entry, no attempt counted); else decrement.
- COMPARE: stay while submitButton; on release -> RESULT, timer=TIMEOUT_CYCLES-1.
- RESULT:
  - invalid_password -> CHECK with fail_cnt+1, saturating at MAX_ATTEMPTS. If invalid_password and correct_password arrive in the same cycle, invalid wins.
  - else correct_password -> UNLOCK, fail_cnt=0, timer=UNLOCK_CYCLES-1.
  - else timer==0 -> treat as invalid (CHECK, fail_cnt+1).
- UNLOCK: unlock=1 for exactly UNLOCK_CYCLES cycles; at timer==0 -> IDLE. Buttons and checker inputs are ignored.
- CHECK (one cycle): fail_cnt>=MAX_ATTEMPTS -> SLEEP, timer=SLEEP_CYCLES-1; else -> IDLE.
- SLEEP: locked_out=1 for exactly SLEEP_CYCLES cycles, all inputs ignored. At timer==0 -> IDLE with fail_cnt=0.
- STORE: stay while storeButton; on release -> WAIT_STORE, timer=TIMEOUT_CYCLES-1.
- WAIT_STORE: storeButton -> STORE; else submitButton -> STORE_PW; else timer==0 -> IDLE; else decrement.
- STORE_PW: store_password=1; stay while submitButton; on release -> IDLE. Storing does not change fail_cnt.
- Unused state encodings -> IDLE on the next clk.
- Reset asserted mid-operation (including UNLOCK or SLEEP) forces IDLE and clears fail_cnt immediately, with all outputs 0.
- The 1-cycle CHECK state is the only latency between the checker verdict and the lockout/IDLE decision.
- A checker pulse is only sampled in RESULT; pulses in any other state are ignored.

Test Plan:
Params MAX_ATTEMPTS=3, SLEEP_CYCLES=20, UNLOCK_CYCLES=8, TIMEOUT_CYCLES=16 for all scenarios.
1. Reset, press/release input, submit, then a correct_password pulse 3 cycles later -> compare high while submit held; unlock high exactly 8 cycles; back to IDLE; attempts_left=3.
2. Three input/submit/invalid_password sequences -> attempts_left goes 2, 1, 0; after the third, locked_out high exactly 20 cycles with buttons toggling ignored; then IDLE, attempts_left=3.
3. Two failures, then one success -> attempts_left goes 2, 1, then 3 after the unlock; no lockout.
4. Submit with no checker response -> RESULT times out after 16 cycles, counted as a failure (attempts_left=2). Separately, input then silence in WAIT_INPUT -> IDLE after 16 cycles, attempts_left unchanged.
5. correct_password and invalid_password in the same cycle in RESULT -> CHECK taken, unlock never asserts, attempts_left decrements.
6. Store path: press/release store, submit -> store_value high in STORE, store_password high while submit held. Pulsing system_reset_n low mid-SLEEP -> locked_out drops asynchronously, state IDLE, attempts_left=3.
